// File: rtl/vga_vram_arbiter_pkg.sv
// Shared definitions for the VGA video-RAM arbiter: slot states and default geometry.
// RAM addresses are always formed as {row, col}, with row in the upper bits.
package vga_vram_arbiter_pkg;

   localparam int DEF_X_WIDTH    = 8;
   localparam int DEF_Y_WIDTH    = 8;
   localparam int DEF_DATA_WIDTH = 3;
   localparam int DEF_FIFO_AW    = 2;

   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_BLANK   = 2'd1,
      ST_DISP_RD = 2'd2,
      ST_DISP_WR = 2'd3
   } vram_state_t;

   // Slots in which a buffered CPU write may be issued to the RAM.
   function automatic logic is_write_slot(input vram_state_t s);
      return (s == ST_BLANK) || (s == ST_DISP_WR);
   endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Small write-buffer FIFO for CPU pixel writes; head word is visible combinationally.
// Full/empty are judged on the pre-edge level, so a push while full is refused even with a pop.
module vga_wr_fifo #(
   parameter int WIDTH = 19,
   parameter int AW    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_level == LVL_FULL);
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   // Storage is deliberately not reset; the level counter alone defines validity.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Arbitrates a single-port video RAM between the VGA read path and buffered CPU writes.
// Display reads own every other cycle of active video; writes use the remaining slots.
module vga_vram_arbiter
   import vga_vram_arbiter_pkg::*;
#(
   parameter int X_WIDTH    = DEF_X_WIDTH,
   parameter int Y_WIDTH    = DEF_Y_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_AW    = DEF_FIFO_AW
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_display,
   input  logic [X_WIDTH-1:0]         i_col,
   input  logic [Y_WIDTH-1:0]         i_row,
   output logic [DATA_WIDTH-1:0]      o_pixel,
   output logic                       o_pixel_valid,
   input  logic                       i_wr_req,
   input  logic [X_WIDTH-1:0]         i_wr_col,
   input  logic [Y_WIDTH-1:0]         i_wr_row,
   input  logic [DATA_WIDTH-1:0]      i_wr_data,
   output logic                       o_wr_ack,
   output logic                       o_wr_full,
   output logic [FIFO_AW:0]           o_fifo_level,
   output logic [X_WIDTH+Y_WIDTH-1:0] o_mem_addr,
   output logic                       o_mem_we,
   output logic [DATA_WIDTH-1:0]      o_mem_wdata,
   input  logic [DATA_WIDTH-1:0]      i_mem_rdata
);

   localparam int MA_W = X_WIDTH + Y_WIDTH;
   localparam int FW   = MA_W + DATA_WIDTH;

   vram_state_t         r_state;
   vram_state_t         w_state_next;

   logic [FW-1:0]       w_push_word;
   logic [FW-1:0]       w_head;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_pop;
   logic [MA_W-1:0]     w_mem_addr;
   logic                w_mem_we;
   logic [MA_W-1:0]     r_addr_hold;

   logic                r_rd_tag;
   logic                r_pixel_valid;
   logic [DATA_WIDTH-1:0] r_pixel;
   logic                r_wr_ack;

   // FIFO word layout: {row, col, data} so the address slice is already in RAM order.
   assign w_push_word = {i_wr_row, i_wr_col, i_wr_data};

   vga_wr_fifo #(
      .WIDTH (FW),
      .AW    (FIFO_AW)
   ) u_wr_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_wr_req),
      .i_wdata (w_push_word),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (o_fifo_level)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_RESET;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_mem_addr   = r_addr_hold;
      w_mem_we     = 1'b0;
      w_pop        = 1'b0;
      case (r_state)
         ST_RESET: begin
            w_state_next = ST_BLANK;
            w_mem_addr   = '0;
         end
         ST_BLANK: begin
            if (i_display) begin
               w_state_next = ST_DISP_RD;
            end
         end
         ST_DISP_RD: begin
            w_state_next = ST_DISP_WR;
            w_mem_addr   = {i_row, i_col};
         end
         ST_DISP_WR: begin
            w_state_next = i_display ? ST_DISP_RD : ST_BLANK;
         end
         default: begin
            w_state_next = ST_RESET;
            w_mem_addr   = '0;
         end
      endcase
      if (is_write_slot(r_state) && !w_fifo_empty) begin
         w_mem_we   = 1'b1;
         w_pop      = 1'b1;
         w_mem_addr = w_head[FW-1:DATA_WIDTH];
      end
   end

   assign o_mem_addr  = w_mem_addr;
   assign o_mem_we    = w_mem_we;
   assign o_mem_wdata = w_head[DATA_WIDTH-1:0];

   // The address register lets an idle write slot keep the bus quiet instead of toggling.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr_hold <= '0;
      end else begin
         r_addr_hold <= w_mem_addr;
      end
   end

   // Read tag follows the issuing slot; RAM data lands one cycle later.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_tag      <= 1'b0;
         r_pixel_valid <= 1'b0;
         r_pixel       <= '0;
         r_wr_ack      <= 1'b0;
      end else begin
         r_rd_tag      <= (r_state == ST_DISP_RD);
         r_pixel_valid <= r_rd_tag;
         if (r_rd_tag) begin
            r_pixel <= i_mem_rdata;
         end
         r_wr_ack      <= i_wr_req && !w_fifo_full;
      end
   end

   assign o_pixel       = r_pixel;
   assign o_pixel_valid = r_pixel_valid;
   assign o_wr_ack      = r_wr_ack;
   assign o_wr_full     = w_fifo_full;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench: behavioural slot model with write and pixel scoreboards plus scenario tasks.
module tb_vga_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        display = 1'b0;
   logic [7:0]  col = '0;
   logic [7:0]  row = '0;
   logic        wr_req = 1'b0;
   logic [7:0]  wr_col = '0;
   logic [7:0]  wr_row = '0;
   logic [2:0]  wr_data = '0;
   logic [2:0]  o_pixel;
   logic        o_pixel_valid;
   logic        o_wr_ack;
   logic        o_wr_full;
   logic [2:0]  o_fifo_level;
   logic [15:0] o_mem_addr;
   logic        o_mem_we;
   logic [2:0]  o_mem_wdata;
   logic [2:0]  ram_rdata = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vga_vram_arbiter dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_display     (display),
      .i_col         (col),
      .i_row         (row),
      .o_pixel       (o_pixel),
      .o_pixel_valid (o_pixel_valid),
      .i_wr_req      (wr_req),
      .i_wr_col      (wr_col),
      .i_wr_row      (wr_row),
      .i_wr_data     (wr_data),
      .o_wr_ack      (o_wr_ack),
      .o_wr_full     (o_wr_full),
      .o_fifo_level  (o_fifo_level),
      .o_mem_addr    (o_mem_addr),
      .o_mem_we      (o_mem_we),
      .o_mem_wdata   (o_mem_wdata),
      .i_mem_rdata   (ram_rdata)
   );

   // Video RAM model: registered read, preloaded with a pattern derived from the address.
   logic [2:0] ram [0:65535];
   initial begin
      for (int a = 0; a < 65536; a++) ram[a] = 3'(a) ^ 3'(a >> 8);
   end
   always @(posedge clk) begin
      ram_rdata <= ram[o_mem_addr];
      if (o_mem_we) ram[o_mem_addr] = o_mem_wdata;
   end

   // Reference model (states: 0 reset, 1 blank, 2 display read, 3 display write).
   int          m_state = 0;
   int          m_level = 0;
   logic        m_ack = 1'b0;
   logic        m_v1 = 1'b0;
   logic        m_v2 = 1'b0;
   logic [15:0] m_addr_hold = '0;
   logic [18:0] exp_wr[$];
   logic [2:0]  exp_pix[$];
   logic        mdl_acc;
   logic        mdl_pop;
   logic [15:0] mdl_addr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_level = 0; m_ack = 1'b0; m_v1 = 1'b0; m_v2 = 1'b0;
         m_addr_hold = '0;
         exp_wr.delete();
         exp_pix.delete();
      end else begin
         mdl_pop = (m_state == 1 || m_state == 3) && (m_level > 0);
         mdl_acc = wr_req && (m_level < 4);
         if (m_state == 0)      mdl_addr = '0;
         else if (m_state == 2) mdl_addr = {row, col};
         else if (mdl_pop)      mdl_addr = exp_wr[0][18:3];
         else                   mdl_addr = m_addr_hold;
         m_addr_hold = mdl_addr;
         if (mdl_pop) void'(exp_wr.pop_front());
         if (mdl_acc) exp_wr.push_back({wr_row, wr_col, wr_data});
         m_level = m_level + int'(mdl_acc) - int'(mdl_pop);
         m_ack = mdl_acc;
         m_v2 = m_v1;
         m_v1 = (m_state == 2);
         case (m_state)
            0: m_state = 1;
            1: m_state = display ? 2 : 1;
            2: m_state = 3;
            default: m_state = display ? 2 : 1;
         endcase
      end
   end

   // Monitor: compares every cycle against the model and scoreboards.
   logic        mon_we;
   logic [15:0] mon_addr;
   logic [2:0]  mon_wd;
   logic [2:0]  mon_pix;
   always @(negedge clk) begin
      mon_we = 1'b0;
      mon_wd = '0;
      if (m_state == 0)      mon_addr = '0;
      else if (m_state == 2) mon_addr = {row, col};
      else if (m_level > 0) begin
         mon_we = 1'b1;
         mon_addr = exp_wr[0][18:3];
         mon_wd = exp_wr[0][2:0];
      end else mon_addr = m_addr_hold;

      n_tests++;
      if (o_mem_we !== mon_we) begin
         n_fail++; $display("FAIL mon_mem_we t=%0t got %b want %b", $time, o_mem_we, mon_we);
      end
      n_tests++;
      if (o_mem_addr !== mon_addr) begin
         n_fail++; $display("FAIL mon_mem_addr t=%0t got %h want %h", $time, o_mem_addr, mon_addr);
      end
      if (mon_we) begin
         n_tests++;
         if (o_mem_wdata !== mon_wd) begin
            n_fail++; $display("FAIL mon_mem_wdata t=%0t got %0d want %0d", $time, o_mem_wdata, mon_wd);
         end else begin
            $display("[TB] write addr=%h data=%0d", o_mem_addr, o_mem_wdata);
         end
      end
      n_tests++;
      if (o_fifo_level !== 3'(m_level) || o_wr_full !== (m_level == 4)) begin
         n_fail++; $display("FAIL mon_level t=%0t got %0d/%b want %0d/%b", $time,
                            o_fifo_level, o_wr_full, m_level, (m_level == 4));
      end
      n_tests++;
      if (o_wr_ack !== m_ack) begin
         n_fail++; $display("FAIL mon_wr_ack t=%0t got %b want %b", $time, o_wr_ack, m_ack);
      end
      n_tests++;
      if (o_pixel_valid !== m_v2) begin
         n_fail++; $display("FAIL mon_pixel_valid t=%0t got %b want %b", $time, o_pixel_valid, m_v2);
      end
      if (m_state == 2) exp_pix.push_back(ram[{row, col}]);
      if (o_pixel_valid === 1'b1 && m_v2) begin
         n_tests++;
         if (exp_pix.size() == 0) begin
            n_fail++; $display("FAIL mon_pixel_underflow t=%0t got %0d want none", $time, o_pixel);
         end else begin
            mon_pix = exp_pix.pop_front();
            if (o_pixel !== mon_pix) begin
               n_fail++; $display("FAIL mon_pixel t=%0t got %0d want %0d", $time, o_pixel, mon_pix);
            end else begin
               $display("[TB] pixel %0d", o_pixel);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int we_seen = 0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({o_pixel_valid, o_wr_ack, o_wr_full, o_mem_we} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags got %b want 0000", {o_pixel_valid, o_wr_ack, o_wr_full, o_mem_we});
      end
      n_tests++;
      if (o_fifo_level !== 3'd0 || o_pixel !== 3'd0 || o_mem_addr !== 16'h0) begin
         n_fail++; $display("FAIL reset_values got lvl=%0d pix=%0d addr=%h want 0", o_fifo_level, o_pixel, o_mem_addr);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_mem_we !== 1'b0) we_seen++;
      end
      n_tests++;
      if (we_seen != 0) begin
         n_fail++; $display("FAIL reset_idle_we got %0d writes want 0", we_seen);
      end
   endtask

   task automatic test_single_write();
      tick();
      wr_req = 1'b1; wr_col = 8'd5; wr_row = 8'd7; wr_data = 3'b101;
      tick();
      wr_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (o_wr_ack !== 1'b1 || o_mem_we !== 1'b1 || o_fifo_level !== 3'd1) begin
         n_fail++; $display("FAIL single_ack_we got ack=%b we=%b lvl=%0d want 1 1 1", o_wr_ack, o_mem_we, o_fifo_level);
      end
      n_tests++;
      if (o_mem_addr !== 16'h0705 || o_mem_wdata !== 3'd5) begin
         n_fail++; $display("FAIL single_addr_data got %h/%0d want 0705/5", o_mem_addr, o_mem_wdata);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (o_fifo_level !== 3'd0 || o_mem_we !== 1'b0 || o_mem_addr !== 16'h0705 || o_wr_ack !== 1'b0) begin
         n_fail++; $display("FAIL single_after got lvl=%0d we=%b addr=%h ack=%b want 0 0 0705 0",
                            o_fifo_level, o_mem_we, o_mem_addr, o_wr_ack);
      end
   endtask

   task automatic test_display_read();
      int n_valid = 0;
      int n_rd = 0;
      tick();
      display = 1'b1; col = 8'd0; row = 8'd3;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (i % 2 == 1) col = col + 8'd1;
         @(negedge clk);
         if (o_pixel_valid === 1'b1) n_valid++;
         if (m_state == 2) n_rd++;
      end
      tick();
      display = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (o_pixel_valid === 1'b1) n_valid++;
         if (m_state == 2) n_rd++;
         tick();
      end
      n_tests++;
      if (n_valid != n_rd || n_rd < 10) begin
         n_fail++; $display("FAIL display_pixel_count got %0d want %0d (>=10)", n_valid, n_rd);
      end
      n_tests++;
      if (exp_pix.size() != 0) begin
         n_fail++; $display("FAIL display_pending got %0d want 0", exp_pix.size());
      end
   endtask

   task automatic drive_item(input int k);
      wr_req = 1'b1;
      wr_col = 8'(k * 3 + 1);
      wr_row = 8'(k + 32);
      wr_data = 3'(k);
   endtask

   task automatic test_fill_full();
      int idx = 0;
      int max_lvl = 0;
      int coincide = 0;
      bit seen_full = 0;
      bit pend = 0;
      bit pend_next = 0;
      display = 1'b1;
      drive_item(0);
      for (int c = 0; c < 60 && idx < 10; c++) begin
         @(negedge clk);
         if (int'(o_fifo_level) > max_lvl) max_lvl = int'(o_fifo_level);
         if (o_wr_full === 1'b1) seen_full = 1;
         if (o_wr_full === 1'b1 && o_mem_we === 1'b1 && wr_req) pend = 1;
         tick();
         if (pend_next) begin
            pend_next = 0;
            n_tests++;
            if (o_wr_ack !== 1'b1 || o_fifo_level !== 3'd4) begin
               n_fail++; $display("FAIL full_retry got ack=%b lvl=%0d want 1 4", o_wr_ack, o_fifo_level);
            end
         end
         if (pend) begin
            pend = 0;
            pend_next = 1;
            coincide++;
            n_tests++;
            if (o_wr_ack !== 1'b0 || o_fifo_level !== 3'd3) begin
               n_fail++; $display("FAIL full_pop_refuse got ack=%b lvl=%0d want 0 3", o_wr_ack, o_fifo_level);
            end
         end
         if (o_wr_ack === 1'b1) begin
            idx++;
            if (idx == 10) wr_req = 1'b0;
            else drive_item(idx);
         end
      end
      wr_req = 1'b0;
      n_tests++;
      if (idx != 10) begin
         n_fail++; $display("FAIL fill_all_acked got %0d want 10", idx);
      end
      n_tests++;
      if (max_lvl != 4 || !seen_full || coincide == 0) begin
         n_fail++; $display("FAIL fill_full got max=%0d full=%0d coincide=%0d want 4 1 >0", max_lvl, seen_full, coincide);
      end
      display = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      n_tests++;
      if (o_fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL fill_drain got %0d want 0", o_fifo_level);
      end
   endtask

   task automatic test_reset_mid();
      int idx = 0;
      int we_seen = 0;
      tick();
      display = 1'b1;
      drive_item(20);
      for (int c = 0; c < 40 && o_fifo_level < 3'd3; c++) begin
         tick();
         if (o_wr_ack === 1'b1) begin
            idx++;
            drive_item(20 + idx);
         end
      end
      wr_req = 1'b0;
      n_tests++;
      if (o_fifo_level !== 3'd3) begin
         n_fail++; $display("FAIL midrst_level got %0d want 3", o_fifo_level);
      end
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({o_pixel_valid, o_wr_ack, o_wr_full, o_mem_we} !== 4'b0 || o_pixel !== 3'd0) begin
         n_fail++; $display("FAIL midrst_async_flags got %b pix=%0d want 0", {o_pixel_valid, o_wr_ack, o_wr_full, o_mem_we}, o_pixel);
      end
      n_tests++;
      if (o_fifo_level !== 3'd0 || o_mem_addr !== 16'h0) begin
         n_fail++; $display("FAIL midrst_async_level got lvl=%0d addr=%h want 0 0000", o_fifo_level, o_mem_addr);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      display = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (o_mem_we !== 1'b0) we_seen++;
      end
      n_tests++;
      if (we_seen != 0 || o_fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL midrst_discard got writes=%0d lvl=%0d want 0 0", we_seen, o_fifo_level);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_display_read();
      test_fill_full();
      test_reset_mid();
      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
